// File: rtl/adder_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : adder_stim_gen
//  Description : Parametrised operand generator for the adder test harnesses.
//                Emits A, B, cin and the registered expected sum
//                exp_sum = A + B + cin in one of four sequence modes:
//                  0 COUNT      : A = k mod 2^WIDTH, B = 0, cin = 0
//                                 (NUM_VECTORS vectors)
//                  1 EXHAUSTIVE : {cin,B,A} = k (2^(2*WIDTH+1) vectors)
//                  2 RANDOM     : fields of a 32-bit Galois LFSR,
//                                 x^32+x^22+x^2+x+1 (NUM_VECTORS vectors)
//                  3 WALK       : walking one on A, complement on B,
//                                 first cin=0 then cin=1 (2*WIDTH vectors)
//                A run is started with a start pulse in IDLE and is paced
//                by en. done pulses once after the last vector.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       operand width, 1..15
//    NUM_VECTORS vector count for COUNT and RANDOM, >= 1
//    LFSR_SEED   LFSR load value (zero is replaced by 32'h1)
//  Ports
//    clk      in   rising-edge clock
//    rst      in   asynchronous active-low reset
//    start    in   one-cycle start pulse, sampled only in IDLE
//    mode     in   sequence mode, latched on an accepted start
//    en       in   advance enable while running
//    A, B     out  operands (WIDTH bits)
//    cin      out  carry-in
//    exp_sum  out  expected sum (WIDTH+1 bits), aligned with A/B/cin
//    valid    out  a new vector is presented this cycle
//    busy     out  a run is in progress (start edge through done cycle)
//    done     out  one-cycle pulse after the last vector
//  Build option
//    NEGEDGE_LAUNCH_EN  when defined, A, B, cin, exp_sum and valid are
//                       relaunched from the falling edge (half-cycle of
//                       setup for a rising-edge DUT). done/busy unaffected.
// ============================================================================
module adder_stim_gen #(
  parameter int          WIDTH       = 4,
  parameter int          NUM_VECTORS = 16,
  parameter logic [31:0] LFSR_SEED   = 32'hACE10001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             en,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             cin,
  output logic [WIDTH:0]   exp_sum,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_mode_count = 2'd0;
  localparam logic [1:0] c_mode_exh   = 2'd1;
  localparam logic [1:0] c_mode_rand  = 2'd2;
  localparam logic [1:0] c_mode_walk  = 2'd3;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] c_seed = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

  // Low-order terms x^22 + x^2 + x + 1 of the feedback polynomial; the
  // LFSR step is a multiply by x modulo the polynomial.
  localparam logic [31:0] c_poly_mask = 32'h0040_0007;

  // Run lengths per mode. WIDTH <= 15 keeps 2^(2*WIDTH+1) within 32 bits.
  localparam logic [31:0] c_total_count = 32'(NUM_VECTORS);
  localparam logic [31:0] c_total_exh   = 32'd1 << (2 * WIDTH + 1);
  localparam logic [31:0] c_total_walk  = 32'(2 * WIDTH);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [1:0]        r_mode;
  logic [31:0]       r_idx;
  logic [31:0]       r_lfsr;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_cin;
  logic [WIDTH:0]    r_sum;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_load;     // accepted start: latch mode, rewind sequence
  logic              w_emit;     // register the next vector on this edge
  logic              w_last;     // the vector about to be emitted is the last
  logic [31:0]       w_total;
  logic [31:0]       w_walk_i;
  logic [31:0]       w_lfsr_step;

  logic [WIDTH-1:0]  w_nxt_a;
  logic [WIDTH-1:0]  w_nxt_b;
  logic              w_nxt_cin;
  logic [WIDTH:0]    w_nxt_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The done pulse is the cycle after the DONE state; a start arriving in
  // that cycle still belongs to the finishing run and is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !r_done) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (en) begin
          w_emit = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequence length and next-vector generation
  // --------------------------------------------------------------------------
  always_comb begin
    w_total = c_total_count;
    case (r_mode)
      c_mode_count: w_total = c_total_count;
      c_mode_exh:   w_total = c_total_exh;
      c_mode_rand:  w_total = c_total_count;
      c_mode_walk:  w_total = c_total_walk;
      default:      w_total = c_total_count;
    endcase
  end

  assign w_last = (r_idx == (w_total - 32'd1));

  assign w_lfsr_step = {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? c_poly_mask : 32'd0);

  // WALK visits bit positions 0..WIDTH-1 twice; the second pass has cin=1.
  assign w_walk_i = (r_idx >= 32'(WIDTH)) ? (r_idx - 32'(WIDTH)) : r_idx;

  always_comb begin
    w_nxt_a   = '0;
    w_nxt_b   = '0;
    w_nxt_cin = 1'b0;
    case (r_mode)
      c_mode_count: begin
        w_nxt_a = r_idx[WIDTH-1:0];
      end
      c_mode_exh: begin
        {w_nxt_cin, w_nxt_b, w_nxt_a} = r_idx[2*WIDTH:0];
      end
      c_mode_rand: begin
        w_nxt_a   = r_lfsr[WIDTH-1:0];
        w_nxt_b   = r_lfsr[2*WIDTH-1:WIDTH];
        w_nxt_cin = r_lfsr[31];
      end
      default: begin
        w_nxt_a   = c_one << w_walk_i;
        w_nxt_b   = ~(c_one << w_walk_i);
        w_nxt_cin = (r_idx >= 32'(WIDTH));
      end
    endcase
  end

  // Computed from the same next-vector values that load A/B/cin, so the
  // expected sum is never a cycle apart from its operands.
  assign w_nxt_sum = {1'b0, w_nxt_a} + {1'b0, w_nxt_b} + {{WIDTH{1'b0}}, w_nxt_cin};

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode  <= c_mode_count;
      r_idx   <= 32'd0;
      r_lfsr  <= c_seed;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_done  <= (r_state == S_DONE);
      r_busy  <= (w_state_nxt != S_IDLE) || (r_state == S_DONE);
      if (w_load) begin
        r_mode <= mode;
        r_idx  <= 32'd0;
        r_lfsr <= c_seed;
      end else if (w_emit) begin
        r_a   <= w_nxt_a;
        r_b   <= w_nxt_b;
        r_cin <= w_nxt_cin;
        r_sum <= w_nxt_sum;
        r_idx <= r_idx + 32'd1;
        if (r_mode == c_mode_rand) begin
          r_lfsr <= w_lfsr_step;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // --------------------------------------------------------------------------
  // Output launch
  // --------------------------------------------------------------------------
`ifdef NEGEDGE_LAUNCH_EN
  logic [WIDTH-1:0] r_neg_a;
  logic [WIDTH-1:0] r_neg_b;
  logic             r_neg_cin;
  logic [WIDTH:0]   r_neg_sum;
  logic             r_neg_valid;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_neg_a     <= '0;
      r_neg_b     <= '0;
      r_neg_cin   <= 1'b0;
      r_neg_sum   <= '0;
      r_neg_valid <= 1'b0;
    end else begin
      r_neg_a     <= r_a;
      r_neg_b     <= r_b;
      r_neg_cin   <= r_cin;
      r_neg_sum   <= r_sum;
      r_neg_valid <= r_valid;
    end
  end

  assign A       = r_neg_a;
  assign B       = r_neg_b;
  assign cin     = r_neg_cin;
  assign exp_sum = r_neg_sum;
  assign valid   = r_neg_valid;
`else
  assign A       = r_a;
  assign B       = r_b;
  assign cin     = r_cin;
  assign exp_sum = r_sum;
  assign valid   = r_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_stim_gen
//  Description : Self-checking bench for adder_stim_gen (WIDTH=4,
//                NUM_VECTORS=20, default seed). Expected vectors come from
//                an arithmetic reference of each sequence mode; the LFSR is
//                modelled as multiplication by x modulo x^32+x^22+x^2+x+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_stim_gen;

  localparam int          TB_W  = 4;
  localparam int          TB_NV = 20;
  localparam logic [31:0] TB_SEED = 32'hACE10001;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      mode;
  logic            en;
  logic [TB_W-1:0] A;
  logic [TB_W-1:0] B;
  logic            cin;
  logic [TB_W:0]   exp_sum;
  logic            valid;
  logic            busy;
  logic            done;

  int n_checks;
  int n_errors;

  // Last vector the model expects on the outputs, plus a few snapshots.
  logic [13:0] last_v;
  logic [13:0] first_v;
  logic [13:0] fifth_v;

  adder_stim_gen #(
    .WIDTH       (TB_W),
    .NUM_VECTORS (TB_NV),
    .LFSR_SEED   (TB_SEED)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .en      (en),
    .A       (A),
    .B       (B),
    .cin     (cin),
    .exp_sum (exp_sum),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Multiply the field element by x modulo the LFSR polynomial.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [32:0] v;
    v = {s, 1'b0};
    if (v[32]) v = v ^ 33'h1_0040_0007;
    return v[31:0];
  endfunction

  // Expected {A,B,cin,exp_sum} for vector k of mode m.
  function automatic logic [13:0] vec_of(input logic [1:0] m, input int k, input logic [31:0] lf);
    int a, b, c;
    case (m)
      2'd0: begin a = k % 16; b = 0; c = 0; end
      2'd1: begin a = k % 16; b = (k / 16) % 16; c = k / 256; end
      2'd2: begin a = int'(lf[3:0]); b = int'(lf[7:4]); c = int'(lf[31]); end
      default: begin a = 1 << (k % TB_W); b = 15 - a; c = k / TB_W; end
    endcase
    return {4'(a), 4'(b), 1'(c), 5'(a + b + c)};
  endfunction

  function automatic logic [31:0] outs();
    return 32'({A, B, cin, exp_sum});
  endfunction

  // One complete run. pat: 0 = en always 1, 1 = random en, 2 = 1,0,0,1 repeating.
  // poke: pulse start in the middle of the run (must be ignored).
  // Called just after a falling edge.
  task automatic run_mode(input logic [1:0] m, input int pat, input bit poke);
    int          total, k, cyc, nvalid;
    logic [31:0] lf;
    bit          e;
    total  = (m == 2'd1) ? 512 : (m == 2'd3) ? 2 * TB_W : TB_NV;
    k      = 0;
    nvalid = 0;
    lf     = TB_SEED;
    start  = 1'b1;
    mode   = m;
    en     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    check("busy_start", 32'(busy), 32'd1);
    check("valid_start", 32'(valid), 32'd0);
    cyc = 0;
    while (k < total && cyc < total * 4 + 20) begin
      case (pat)
        0:       e = 1'b1;
        1:       e = 1'($urandom_range(0, 1));
        default: e = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      en    = e;
      start = poke && (cyc == 3);
      @(negedge clk);
      cyc++;
      if (e) begin
        last_v = vec_of(m, k, lf);
        if (k == 0) first_v = last_v;
        if (k == 4) fifth_v = last_v;
        lf = lfsr_next(lf);
        k++;
      end
      nvalid += int'(valid);
      check("valid", 32'(valid), 32'(e));
      check("vector", outs(), 32'(last_v));
      check("sum_consistent", 32'(exp_sum), 32'(A) + 32'(B) + 32'(cin));
      check("done_in_run", 32'(done), 32'd0);
      check("busy_in_run", 32'(busy), 32'd1);
    end
    start = 1'b0;
    en    = 1'($urandom_range(0, 1));
    check("valid_count", 32'(nvalid), 32'(total));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("valid_at_done", 32'(valid), 32'd0);
    check("busy_at_done", 32'(busy), 32'd1);
    check("hold_at_done", outs(), 32'(last_v));
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("hold_idle", outs(), 32'(last_v));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_v   = '0;
    first_v  = '0;
    fifth_v  = '0;
    rst      = 1'b0;
    start    = 1'b0;
    mode     = 2'd0;
    en       = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 32'd0);
    check("reset_ctrl", 32'({valid, busy, done}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ctrl", 32'({valid, busy, done}), 32'd0);

    // EXHAUSTIVE: 512 vectors, first all-zero, last all-ones.
    run_mode(2'd1, 0, 1'b0);
    check("exh_first", 32'(first_v), 32'd0);
    check("exh_last", 32'(last_v), 32'({4'd15, 4'd15, 1'b1, 5'd31}));

    // COUNT with the 1,0,0,1 en pattern and an ignored start mid-run.
    run_mode(2'd0, 2, 1'b1);

    // RANDOM from the default seed.
    run_mode(2'd2, 0, 1'b0);
    check("rand_v0", 32'(first_v), 32'({4'd1, 4'd0, 1'b1, 5'd2}));

    // WALK with random en.
    run_mode(2'd3, 1, 1'b0);
    check("walk_first", 32'(first_v), 32'({4'd1, 4'd14, 1'b0, 5'd15}));
    check("walk_fifth", 32'(fifth_v), 32'({4'd1, 4'd14, 1'b1, 5'd16}));

    // COUNT with random en and a mid-run start pulse.
    run_mode(2'd0, 1, 1'b1);

    // Reset in the middle of a RANDOM run, away from any clock edge.
    start = 1'b1;
    mode  = 2'd2;
    en    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_outs", outs(), 32'd0);
    check("midrst_ctrl", 32'({valid, busy, done}), 32'd0);
    last_v = '0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", 32'({valid, busy, done}), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'({valid, busy, done}), 32'd0);

    // Restart must begin from vector 0 with the LFSR reseeded.
    first_v = '0;
    run_mode(2'd2, 1, 1'b0);
    check("rand_v0_reseed", 32'(first_v), 32'({4'd1, 4'd0, 1'b1, 5'd2}));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/adder_stim_gen.md
Name: adder_stim_gen

Overview:
Parametrised, synthesizable operand generator for the adder test harnesses. Replaces the fixed 4-bit free-running counter stimulus. Drives A, B and carry-in plus a registered expected sum, in four selectable sequence modes, under a start/enable/done handshake. Sits between the harness controller and the adder DUT and scoreboard.

Parameters:
WIDTH, 4, operand width; legal range 1..15.
NUM_VECTORS, 16, vector count for COUNT and RANDOM modes; legal range ≥1.
LFSR_SEED, 32'hACE10001, LFSR load value; a zero seed is replaced by 32'h1.

Ports:
clk  input  1  clock, rising-edge active.
rst  input  1  reset; asynchronous, active-low.
start  input  1  one-cycle pulse; sampled only in IDLE.
mode  input  2  0=COUNT, 1=EXHAUSTIVE, 2=RANDOM, 3=WALK; latched on an accepted start.
en  input  1  advance enable while RUN.
A  output  WIDTH  operand A.
B  output  WIDTH  operand B.
cin  output  1  carry-in.
exp_sum  output  WIDTH+1  A+B+cin, registered with A, B and cin.
valid  output  1  a new vector is presented this cycle.
busy  output  1  state is RUN or DONE.
done  output  1  one-cycle pulse after the last vector.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. A, B, cin, exp_sum, valid, busy and done are all 0. Vector index is 0. LFSR is loaded with the seed.
- FSM states and transitions:
  - IDLE -> RUN when start=1. On that edge, mode is latched, the index is cleared and the LFSR is reloaded.
  - RUN -> DONE on the edge that emits the last vector.
  - DONE -> IDLE unconditionally after one cycle.
- start is ignored in RUN and DONE. Changes on mode after it is latched have no effect.
- Timing: start accepted at edge t. The first vector is registered at edge t+1 if en=1.
  - Each RUN edge with en=1 registers the next vector and sets valid=1.
  - An edge with en=0 holds A, B, cin and exp_sum, and clears valid.
- DONE: valid=0 and done=1 for exactly one cycle. A, B, cin and exp_sum hold the last vector until the next run.
- busy is 1 from edge t through the DONE cycle.
- Vector k, starting at k=0, per mode:
  - COUNT: A = k mod 2^WIDTH (wraps); B=0; cin=0. Total NUM_VECTORS.
  - EXHAUSTIVE: {cin,B,A} = k over the width 2*WIDTH+1. Total 2^(2*WIDTH+1); last vector is all ones.
  - RANDOM: 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1.
    - Vector 0 uses the seed state.
    - The LFSR steps once after each emitted vector.
    - A = lfsr[WIDTH-1:0], B = lfsr[2*WIDTH-1:WIDTH], cin = lfsr[31].
    - Total NUM_VECTORS.
  - WALK: for i in 0..WIDTH-1: A = 1<<i, B = ~(1<<i), cin=0. Then the same i sequence with cin=1. Total 2*WIDTH.
- exp_sum is computed at full width WIDTH+1 from the same next-vector values, so it is never skewed from the operands.
- Reset mid-run aborts immediately to the reset values. done is not pulsed.
- The LFSR never reaches the all-zero state.

Optional Feature:
NEGEDGE_LAUNCH_EN
- Defined: A, B, cin, exp_sum and valid pass through an extra falling-edge register, giving the DUT a half-cycle of setup before its rising-edge sample.
  - Outputs change half a cycle after the internal update.
  - The retiming register is also asynchronously cleared by rst.
  - done and busy stay rising-edge.
- Undefined: all outputs are launched directly from the rising edge, as specified above.

Test Plan:
1. WIDTH=4, mode=1, start then en held at 1 -> exactly 512 valid vectors. First vector: A=0, B=0, cin=0, exp_sum=0. Last vector: A=15, B=15, cin=1, exp_sum=31. done pulses once the cycle after the last vector.
2. mode=0, NUM_VECTORS=20 -> A runs 0..15 then wraps to 0..3; B=0; 20 valid pulses, then done.
3. mode=2, default seed -> vector 0: A=1, B=0, cin=1, exp_sum=2. Every exp_sum equals A+B+cin. No vector is all-zero LFSR state.
4. mode=3, WIDTH=4 -> 8 vectors. First: A=1, B=14, exp_sum=15. Fifth: A=1, B=14, cin=1, exp_sum=16.
5. en toggled 1,0,0,1 during RUN -> valid pattern 1,0,0,1 with operands held across the gaps. A start pulse during RUN is ignored and the vector count is unchanged.
6. rst=0 asserted mid-run, off the clock edge -> all outputs go to 0 immediately with no done pulse. A new start restarts from vector 0 with the LFSR reseeded.
